// File: rtl/serial_mofn_checker.sv
// serial_mofn_checker: frames a qualified serial bit stream into N-bit words.
// For each complete word it pulses valid when the word has exactly M ones,
// and pulses invalid otherwise. A new word can start in the cycle right
// after the previous one completes, so back-to-back words lose no bits.
//
// Optional build macro MOFN_ERRCNT_EN adds err_cnt, a saturating count of
// invalid words that is cleared only by reset.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no partial word held, counters at zero
// S_COLLECT | partial word held (1..N-1 bits sampled)
// S_DONE    | word completed last edge; result strobe is visible this cycle
module serial_mofn_checker #(
  parameter int N    = 5,
  parameter int M    = 2,
  parameter int ERRW = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     din,
  input  logic                     din_en,
  input  logic                     sync,
  output logic                     valid,
  output logic                     invalid,
  output logic [$clog2(N+1)-1:0]   bit_pos,
  output logic [$clog2(N+1)-1:0]   ones_cnt
`ifdef MOFN_ERRCNT_EN
  ,
  output logic [ERRW-1:0]          err_cnt
`endif
);

  localparam int CW = $clog2(N+1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [CW-1:0] LAST_POS = CW'(N - 1);
  localparam logic [CW-1:0] M_ONES   = CW'(M);

  generate
    if (N < 2 || M < 0 || M > N) begin : g_bad_params
      $error("serial_mofn_checker: need 2 <= N and 0 <= M <= N");
    end
  endgenerate

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] pos_nxt, ones_nxt;
  logic [CW-1:0] ones_inc;
  logic          word_done;
  logic          valid_nxt, invalid_nxt;

  // ones count including the bit currently on din; also the final count
  // of a word on its completing sample
  assign ones_inc = ones_cnt + CW'(din);

  // next-state and counter logic; the completing sample clears the counters
  // so bit_pos stays within 0..N-1 and the next word starts from zero
  always_comb begin
    state_nxt = state;
    pos_nxt   = bit_pos;
    ones_nxt  = ones_cnt;
    word_done = 1'b0;
    if (sync) begin
      // partial word is dropped; a sample in the same cycle opens a new word
      state_nxt = din_en ? S_COLLECT : S_IDLE;
      pos_nxt   = din_en ? CW'(1) : '0;
      ones_nxt  = din_en ? CW'(din) : '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (din_en) begin
            state_nxt = S_COLLECT;
            pos_nxt   = CW'(1);
            ones_nxt  = CW'(din);
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_COLLECT: begin
          if (din_en) begin
            if (bit_pos == LAST_POS) begin
              word_done = 1'b1;
              state_nxt = S_DONE;
              pos_nxt   = '0;
              ones_nxt  = '0;
            end else begin
              pos_nxt  = bit_pos + CW'(1);
              ones_nxt = ones_inc;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          pos_nxt   = '0;
          ones_nxt  = '0;
        end
      endcase
    end
  end

  assign valid_nxt   = word_done && (ones_inc == M_ONES);
  assign invalid_nxt = word_done && (ones_inc != M_ONES);

  // state, counters and registered one-cycle result strobes
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= S_IDLE;
      bit_pos  <= '0;
      ones_cnt <= '0;
      valid    <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_pos  <= pos_nxt;
      ones_cnt <= ones_nxt;
      valid    <= valid_nxt;
      invalid  <= invalid_nxt;
    end
  end

`ifdef MOFN_ERRCNT_EN
  // saturating invalid-word counter, steps on the same edge invalid rises
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      err_cnt <= '0;
    end else if (invalid_nxt && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_serial_mofn_checker.sv
// Bench for serial_mofn_checker: directed scenarios followed by random
// traffic, all checked against a queue-based word model.
module tb_serial_mofn_checker;

  localparam int N    = 5;
  localparam int M    = 2;
  localparam int ERRW = 2;
  localparam int CW   = $clog2(N+1);

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          din = 1'b0;
  logic          din_en = 1'b0;
  logic          sync = 1'b0;
  logic          valid, invalid;
  logic [CW-1:0] bit_pos, ones_cnt;
`ifdef MOFN_ERRCNT_EN
  logic [ERRW-1:0] err_cnt;
  int              m_err = 0;
`endif

  int total = 0;
  int bad   = 0;
  bit m_word[$];

  always #5 clk = ~clk;

  serial_mofn_checker #(.N(N), .M(M), .ERRW(ERRW)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .din      (din),
    .din_en   (din_en),
    .sync     (sync),
    .valid    (valid),
    .invalid  (invalid),
    .bit_pos  (bit_pos),
    .ones_cnt (ones_cnt)
`ifdef MOFN_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_ones();
    int c = 0;
    foreach (m_word[i]) c += int'(m_word[i]);
    return c;
  endfunction

  // one clock: drive inputs, take the edge, update model, compare
  task automatic cyc(input bit d, input bit e, input bit s);
    bit ev, eiv;
    int ones;
    din = d; din_en = e; sync = s;
    @(posedge clk);
    #1;
    ev = 1'b0; eiv = 1'b0;
    if (s) m_word.delete();
    if (e) begin
      m_word.push_back(d);
      if (m_word.size() == N) begin
        ones = model_ones();
        ev   = (ones == M);
        eiv  = !ev;
        m_word.delete();
`ifdef MOFN_ERRCNT_EN
        if (eiv && m_err < 2**ERRW - 1) m_err++;
`endif
      end
    end
    chk("valid",    32'(valid),    32'(ev));
    chk("invalid",  32'(invalid),  32'(eiv));
    chk("bit_pos",  32'(bit_pos),  m_word.size());
    chk("ones_cnt", 32'(ones_cnt), model_ones());
`ifdef MOFN_ERRCNT_EN
    chk("err_cnt",  32'(err_cnt),  m_err);
`endif
  endtask

  task automatic do_reset();
    din_en = 1'b0; sync = 1'b0; din = 1'b0;
    resetN = 1'b0;
    #2;
    chk("rst_valid",    32'(valid),    0);
    chk("rst_invalid",  32'(invalid),  0);
    chk("rst_bit_pos",  32'(bit_pos),  0);
    chk("rst_ones_cnt", 32'(ones_cnt), 0);
`ifdef MOFN_ERRCNT_EN
    chk("rst_err_cnt",  32'(err_cnt),  0);
    m_err = 0;
`endif
    m_word.delete();
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  // word bits are sent msb first, so 5'b01100 sends 0,1,1,0,0
  task automatic send_word(input bit [N-1:0] w, input int gap);
    for (int i = N-1; i >= 0; i--) begin
      cyc(w[i], 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'($urandom_range(0,1)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1;
    do_reset();
    cyc(1'b0, 1'b0, 1'b0);

    // single valid word, continuous qualifier
    send_word(5'b01100, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // invalid word immediately followed by a valid word
    send_word(5'b11100, 0);
    send_word(5'b10010, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // qualifier gaps inside a word
    send_word(5'b01010, 3);
    cyc(1'b0, 1'b0, 1'b0);

    // resync mid-word with a sample in the sync cycle
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // sync in the cycle after completion must not kill the strobe
    send_word(5'b00011, 0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    // reset after three bits, then a fresh word
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(5'b10001, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // reset right after completion drops the pending strobe
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    din = 1'b0; din_en = 1'b1; sync = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    cyc(1'b0, 1'b0, 1'b0);

    // consecutive all-ones words (invalid; saturates the error counter)
    for (int k = 0; k < 5; k++) send_word('1, 0);
    cyc(1'b0, 1'b0, 1'b0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 39) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
